// File: rtl/alu_ctrl_stage.sv
// ALU control for the ID/EX boundary: decodes ALUOp/funct into a registered ALU select.
// Latency 1 edge; mult/div hold EX for MUL_LAT/DIV_LAT cycles while busy freezes the front end.
// Backpressure: stall holds the EX register only while idle; busy tells upstream to hold.
module alu_ctrl_stage #(
  parameter int FUNCT_W = 6,
  parameter int ALUOP_W = 3,
  parameter int SIG_W   = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [SIG_W-1:0]   alu_sig,
  output logic               illegal,
  output logic               busy,
  output logic               mc_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [ALUOP_W-1:0] OP_ADD = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] OP_SUB = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] OP_R   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] OP_AND = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] OP_OR  = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] OP_SLT = ALUOP_W'(3'b101);

  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_XOR  = FUNCT_W'(6'b100110);
  localparam logic [FUNCT_W-1:0] FN_NOR  = FUNCT_W'(6'b100111);
  localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(6'b101010);
  localparam logic [FUNCT_W-1:0] FN_SLL  = FUNCT_W'(6'b000000);
  localparam logic [FUNCT_W-1:0] FN_SRL  = FUNCT_W'(6'b000010);
  localparam logic [FUNCT_W-1:0] FN_MULT = FUNCT_W'(6'b011000);
  localparam logic [FUNCT_W-1:0] FN_DIV  = FUNCT_W'(6'b011010);

  localparam logic [SIG_W-1:0] SIG_ADD  = SIG_W'(4'b0000);
  localparam logic [SIG_W-1:0] SIG_SUB  = SIG_W'(4'b0001);
  localparam logic [SIG_W-1:0] SIG_AND  = SIG_W'(4'b0010);
  localparam logic [SIG_W-1:0] SIG_OR   = SIG_W'(4'b0011);
  localparam logic [SIG_W-1:0] SIG_XOR  = SIG_W'(4'b0100);
  localparam logic [SIG_W-1:0] SIG_NOR  = SIG_W'(4'b0101);
  localparam logic [SIG_W-1:0] SIG_SLT  = SIG_W'(4'b0110);
  localparam logic [SIG_W-1:0] SIG_SLL  = SIG_W'(4'b0111);
  localparam logic [SIG_W-1:0] SIG_SRL  = SIG_W'(4'b1000);
  localparam logic [SIG_W-1:0] SIG_MULT = SIG_W'(4'b1001);
  localparam logic [SIG_W-1:0] SIG_DIV  = SIG_W'(4'b1010);

  typedef enum logic [0:0] {IDLE, MC_BUSY} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [SIG_W-1:0] dec_sig;
  logic             dec_ill;
  logic             dec_mul;
  logic             dec_div;

  // Unsupported encodings fall back to the add code with illegal raised.
  always_comb begin
    dec_sig = SIG_ADD;
    dec_ill = 1'b0;
    dec_mul = 1'b0;
    dec_div = 1'b0;
    case (alu_op)
      OP_ADD: dec_sig = SIG_ADD;
      OP_SUB: dec_sig = SIG_SUB;
      OP_AND: dec_sig = SIG_AND;
      OP_OR:  dec_sig = SIG_OR;
      OP_SLT: dec_sig = SIG_SLT;
      OP_R: begin
        case (funct)
          FN_ADD:  dec_sig = SIG_ADD;
          FN_SUB:  dec_sig = SIG_SUB;
          FN_AND:  dec_sig = SIG_AND;
          FN_OR:   dec_sig = SIG_OR;
          FN_XOR:  dec_sig = SIG_XOR;
          FN_NOR:  dec_sig = SIG_NOR;
          FN_SLT:  dec_sig = SIG_SLT;
          FN_SLL:  dec_sig = SIG_SLL;
          FN_SRL:  dec_sig = SIG_SRL;
          FN_MULT: begin
            dec_sig = SIG_MULT;
            dec_mul = 1'b1;
          end
          FN_DIV: begin
            dec_sig = SIG_DIV;
            dec_div = 1'b1;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_sig   <= '0;
      illegal   <= 1'b0;
      mc_done   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      alu_sig   <= '0;
      illegal   <= 1'b0;
      mc_done   <= 1'b0;
    end else if (state == MC_BUSY) begin
      // EX contents hold; stall and in_valid are irrelevant until the count expires.
      if (cnt == CNT_ONE) begin
        state   <= IDLE;
        cnt     <= '0;
        mc_done <= 1'b1;
      end else begin
        cnt     <= cnt - CNT_ONE;
        mc_done <= 1'b0;
      end
    end else if (stall) begin
      mc_done <= 1'b0;
    end else begin
      out_valid <= in_valid;
      mc_done   <= 1'b0;
      if (in_valid) begin
        alu_sig <= dec_sig;
        illegal <= dec_ill;
        if (dec_mul || dec_div) begin
          state <= MC_BUSY;
          cnt   <= dec_mul ? MUL_CNT : DIV_CNT;
        end
      end else begin
        alu_sig <= '0;
        illegal <= 1'b0;
      end
    end
  end

  assign busy = (state == MC_BUSY);

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, mult/div sequencing, stall, flush, async reset.
module tb_alu_ctrl_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] funct;
  logic [2:0] alu_op;
  logic       stall;
  logic       flush;
  logic       out_valid;
  logic [3:0] alu_sig;
  logic       illegal;
  logic       busy;
  logic       mc_done;

  int passed = 0;
  int total  = 0;

  alu_ctrl_stage #(
    .FUNCT_W(6), .ALUOP_W(3), .SIG_W(4), .MUL_LAT(4), .DIV_LAT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .funct(funct), .alu_op(alu_op),
    .stall(stall), .flush(flush), .out_valid(out_valid), .alu_sig(alu_sig),
    .illegal(illegal), .busy(busy), .mc_done(mc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_outs(input string tag, input logic ov, input logic [3:0] sig,
                             input logic ill, input logic bz, input logic dn);
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, ov});
    chk({tag, ".alu_sig"},   {4'd0, alu_sig},   {4'd0, sig});
    chk({tag, ".illegal"},   {7'd0, illegal},   {7'd0, ill});
    chk({tag, ".busy"},      {7'd0, busy},      {7'd0, bz});
    chk({tag, ".mc_done"},   {7'd0, mc_done},   {7'd0, dn});
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] fn);
    in_valid = v;
    alu_op   = op;
    funct    = fn;
  endtask

  logic [5:0] r_funct [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                              6'b100111, 6'b101010, 6'b000000, 6'b000010};
  logic [3:0] r_sig   [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                              4'b0101, 4'b0110, 4'b0111, 4'b1000};
  logic [2:0] i_op    [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
  logic [3:0] i_sig   [5] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110};

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'b000, 6'b000000);

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'($urandom);
      alu_op   = 3'($urandom);
      funct    = 6'($urandom);
      stall    = 1'($urandom);
      flush    = 1'($urandom);
      tick();
    end
    expect_outs("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 3'b010, 6'b100000);
    rst_n = 1'b1;
    tick();
    tick();
    expect_outs("post_reset_idle", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // R-type single-cycle sweep
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 3'b010, r_funct[i]);
      tick();
      expect_outs($sformatf("rtype_%0d", i), 1'b1, r_sig[i], 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 3'b010, 6'b111111);
    tick();
    expect_outs("rtype_illegal", 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);

    // Non-R ALUOps ignore funct
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, i_op[i], 6'b011000);
      tick();
      expect_outs($sformatf("aluop_%0d", i), 1'b1, i_sig[i], 1'b0, 1'b0, 1'b0);
    end
    drive(1'b1, 3'b110, 6'b100010);
    tick();
    expect_outs("aluop_110_illegal", 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'b111, 6'b100010);
    tick();
    expect_outs("aluop_111_illegal", 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 3'b010, 6'b100010);
    tick();
    expect_outs("bubble", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // mult: busy after edges 0..2, mc_done after edge 3, in_valid toggling ignored
    drive(1'b1, 3'b010, 6'b011000);
    tick();
    expect_outs("mult_c1", 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'b010, 6'b100010);
    tick();
    expect_outs("mult_c2", 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b100010);
    tick();
    expect_outs("mult_c3", 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'b010, 6'b100010);
    tick();
    expect_outs("mult_done", 1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
    tick();
    expect_outs("mult_after", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    // div with stall during MC_BUSY still completes in 8 cycles
    drive(1'b1, 3'b010, 6'b011010);
    tick();
    expect_outs("div_c1", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    stall = 1'b1;
    drive(1'b1, 3'b010, 6'b100000);
    for (int i = 2; i <= 7; i++) begin
      tick();
      expect_outs($sformatf("div_stall_c%0d", i), 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    end
    tick();
    expect_outs("div_done", 1'b1, 4'hA, 1'b0, 1'b0, 1'b1);
    tick();
    expect_outs("idle_stall_frozen", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    tick();
    expect_outs("idle_stall_frozen2", 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    drive(1'b1, 3'b010, 6'b100010);
    tick();
    expect_outs("after_stall_sub", 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);

    // Flush in the second busy cycle of div
    drive(1'b1, 3'b010, 6'b011010);
    tick();
    expect_outs("divf_c1", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    expect_outs("divf_c2", 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    expect_outs("divf_flushed", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("divf_no_done_%0d", i), {7'd0, mc_done}, 8'd0);
    end
    drive(1'b1, 3'b010, 6'b100000);
    tick();
    expect_outs("divf_next_add", 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);

    // Flush together with stall: flush wins
    drive(1'b1, 3'b010, 6'b100111);
    tick();
    expect_outs("pre_flush_nor", 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    expect_outs("flush_stall", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    stall = 1'b0;
    flush = 1'b0;

    // Flush in the last MC_BUSY cycle of mult suppresses mc_done
    drive(1'b1, 3'b010, 6'b011000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    tick();
    expect_outs("multf_c3", 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    expect_outs("multf_last", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    flush = 1'b0;

    // Async reset mid-mult, between clock edges
    drive(1'b1, 3'b010, 6'b011000);
    tick();
    drive(1'b0, 3'b000, 6'b000000);
    tick();
    expect_outs("arst_pre", 1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_outs("arst_immediate", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    expect_outs("arst_after", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
# alu_ctrl_stage

Registered, parametrised ALU control unit for the ID/EX boundary of the pipelined processor. Decodes ALUOp and funct into an ALU select code, holds it in the EX stage register, and sequences multi-cycle multiply/divide operations. During those operations it asserts `busy` so the hazard unit freezes the front end. It also flags unsupported encodings instead of leaving the select undefined.

## Interface
- `FUNCT_W`, 6: width of funct field.
- `ALUOP_W`, 3: width of ALUOp from main control.
- `SIG_W`, 4: width of ALU select code (must be ≥4).
- `MUL_LAT`, 4: total EX cycles for mult (≥2).
- `DIV_LAT`, 8: total EX cycles for div (≥2).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ID stage holds a valid instruction.
- `funct`  in  FUNCT_W  R-type function field.
- `alu_op`  in  ALUOP_W  ALUOp from main control.
- `stall`  in  1  hazard unit: hold EX register.
- `flush`  in  1  squash EX contents (branch/exception).
- `out_valid`  out  1  EX stage holds a valid op.
- `alu_sig`  out  SIG_W  registered ALU select.
- `illegal`  out  1  registered: captured encoding unsupported.
- `busy`  out  1  multi-cycle op in progress; upstream must hold.
- `mc_done`  out  1  one-cycle pulse on final cycle of mult/div.

## Operation
Decode (combinational, fully specified, no latches):
- ALUOp 000 → add 0000 (lw/sw/addi). ALUOp 001 → sub 0001 (beq/bne). ALUOp 011 → and 0010. ALUOp 100 → or 0011. ALUOp 101 → slt 0110.
- ALUOp 010 (R-type), by funct:
  - 100000 add 0000; 100010 sub 0001; 100100 and 0010; 100101 or 0011.
  - 100110 xor 0100; 100111 nor 0101; 101010 slt 0110.
  - 000000 sll 0111; 000010 srl 1000; 011000 mult 1001; 011010 div 1010.
- Any other ALUOp/funct → alu_sig 0000, illegal 1. Illegal ops are single-cycle.
- Codes are zero-extended to SIG_W.

FSM states: IDLE and MC_BUSY. Down-counter `cnt` is $clog2(max(MUL_LAT,DIV_LAT)+1) bits wide.

Update priority at each rising edge:
1. flush: out_valid/alu_sig/illegal/mc_done ← 0, state ← IDLE, cnt ← 0. Aborts any multi-cycle op.
2. MC_BUSY: outputs hold, cnt decrements, `stall` and `in_valid` are ignored.
   - At cnt==1: state ← IDLE, cnt ← 0, mc_done ← 1.
3. IDLE with stall: all registers hold. mc_done ← 0.
4. IDLE without stall: out_valid ← in_valid.
   - If in_valid: alu_sig/illegal ← decode. Otherwise alu_sig/illegal ← 0 (bubble).
   - If the captured op is mult/div: state ← MC_BUSY, cnt ← LAT−1.
   - mc_done ← 0.
- `busy` = (state==MC_BUSY), combinational from the state register.

## Timing
- Reset (async assert, sync release): out_valid 0, alu_sig 0, illegal 0, busy 0, mc_done 0, state IDLE, cnt 0.
- Latency: decode appears on outputs one edge after capture.
- Single-cycle op: occupies EX for 1 cycle.
- mult/div: occupies EX for LAT cycles.
  - busy is high for the LAT−1 cycles after capture.
  - mc_done is high in the cycle after the final decrement, coinciding with busy low.
- Back-to-back: a new op is captured on the first edge where state is IDLE and stall is low.
- Simultaneous flush+stall: flush wins. Flush in the last MC_BUSY cycle: no mc_done pulse.
- Reset mid-operation: immediate return to reset values. No partial pulse.

## Test plan
- Reset: hold rst_n=0 with random inputs → all outputs 0. Release → stays 0 until the first valid capture.
- R-type sweep, ALUOp=010: each funct from the table with in_valid=1 → alu_sig matches the table next cycle, illegal=0. funct=111111 → alu_sig 0000, illegal 1, out_valid 1.
- mult, MUL_LAT=4: captured at edge 0 → busy high cycles 1–3, mc_done=1 in cycle 4, alu_sig=1001 held throughout. in_valid toggling during busy is ignored.
- div with stall=1 asserted during MC_BUSY → counter still completes in 8 cycles total. Then stall=1 in IDLE → outputs frozen.
- flush in the second busy cycle of div → next edge: out_valid 0, busy 0, mc_done never pulses. A following add is captured normally.
- Asynchronous reset asserted mid-mult (not on an edge) → busy and outputs drop to 0 immediately, without waiting for clk.
